// File: rtl/raster_fb_writer_pkg.sv
// Shared definitions for the raster frame-buffer writer: default raster
// geometry, pixel/coordinate widths and the writer FSM state encoding.
package raster_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int COLOR_W   = 3;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;

  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_DRAW      = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } fb_state_t;

endpackage

// File: rtl/raster_fb_writer_fb_addr_gen.sv
// Combinational pixel address generator: checks that a pixel lies inside
// the visible raster and forms {bank, y*H_RES + x}. The range check gates
// the write, so the truncated linear address never wraps for a valid pixel.
module fb_addr_gen
  import raster_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 20
) (
  input  logic              bank,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic              in_range,
  output logic [ADDR_W-1:0] addr
);

  localparam int LIN_W = ADDR_W - 1;

  logic [LIN_W-1:0] lin;

  assign in_range = (32'(x) < 32'(H_RES)) && (32'(y) < 32'(V_RES));
  assign lin      = LIN_W'(32'(y) * 32'(H_RES) + 32'(x));
  assign addr     = {bank, lin};

endmodule

// File: rtl/raster_fb_writer.sv
// Frame-buffer endpoint of the rasterizer: clears the back bank to the
// background color, writes accepted pixels into it, and swaps banks on the
// first vsync after the frame is reported done.
module raster_fb_writer
  import raster_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_rd_en,
  input  logic [X_W-1:0]     frame_x,
  input  logic [Y_W-1:0]     frame_y,
  input  logic [COLOR_W-1:0] px_color,
  input  logic               raster_done,
  input  logic [COLOR_W-1:0] bk_color,
  input  logic               vsync,
  output logic               frame_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               disp_bank,
  output logic               swap,
  output logic               drop
);

  localparam int              CNT_W    = ADDR_W - 1;
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(H_RES * V_RES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fb_state_t         state, state_nxt;
  logic [CNT_W-1:0]  clr_cnt;
  logic              pending;
  logic              clr_last;
  logic              accept;
  logic              px_in_range;
  logic [ADDR_W-1:0] px_addr;

  // frame_ready mirrors the DRAW state, so a pixel can only be taken there
  assign accept   = frame_rd_en & frame_ready;
  assign clr_last = (clr_cnt == CLR_LAST);

  fb_addr_gen #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .bank     (~disp_bank),
    .x        (frame_x),
    .y        (frame_y),
    .in_range (px_in_range),
    .addr     (px_addr)
  );

  // Next-state logic: a done seen during the clear skips DRAW entirely
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR:     if (clr_last) state_nxt = (pending | raster_done) ? ST_WAIT_SWAP : ST_DRAW;
      ST_DRAW:      if (raster_done) state_nxt = ST_WAIT_SWAP;
      ST_WAIT_SWAP: if (vsync) state_nxt = ST_CLEAR;
      default:      state_nxt = ST_CLEAR;
    endcase
  end

  // Control registers: state, clear counter, pending done, bank and swap pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_CLEAR;
      clr_cnt     <= '0;
      pending     <= 1'b0;
      disp_bank   <= 1'b0;
      swap        <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_ready <= (state_nxt == ST_DRAW);
      swap        <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_last ? '0 : clr_cnt + CNT_ONE;
          if (clr_last)
            pending <= 1'b0;
          else if (raster_done)
            pending <= 1'b1;
        end
        ST_WAIT_SWAP: begin
          if (vsync) begin
            disp_bank <= ~disp_bank;
            swap      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered write port: clear writes in CLEAR, pixel writes or drops in DRAW
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      drop      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      drop   <= 1'b0;
      if (state == ST_CLEAR) begin
        mem_we    <= 1'b1;
        mem_addr  <= {~disp_bank, clr_cnt};
        mem_wdata <= bk_color;
      end else if (accept) begin
        if (px_in_range) begin
          mem_we    <= 1'b1;
          mem_addr  <= px_addr;
          mem_wdata <= px_color;
        end else begin
          drop <= 1'b1;
        end
      end
    end
  end

endmodule
